// File: rtl/serial_adder.sv
`default_nettype none
// ============================================================================
//  Module   : serial_adder
//  Purpose  : Multi-cycle adder producing A + B + Cin one CHUNK per clock,
//             with a start/busy/done handshake and a registered chunk carry.
//  Revision : 1.0 - initial release
// ============================================================================
module serial_adder #(
    parameter int WIDTH = 32,
    parameter int CHUNK = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] Sum,
    output logic             Cout
);

    localparam int c_N    = WIDTH / CHUNK;
    localparam int c_IDXW = (c_N > 1) ? $clog2(c_N) : 1;

    localparam logic [0:0]        c_IDLE     = 1'b0;
    localparam logic [0:0]        c_RUN      = 1'b1;
    localparam logic [c_IDXW-1:0] c_LAST_IDX = c_IDXW'(c_N - 1);

    generate
        if ((CHUNK < 1) || (WIDTH % CHUNK != 0)) begin : g_bad_params
            $error("serial_adder: WIDTH must be a positive multiple of CHUNK");
        end
    endgenerate

    logic [0:0]        r_state;
    logic [WIDTH-1:0]  r_a;
    logic [WIDTH-1:0]  r_b;
    logic [WIDTH-1:0]  r_acc;
    logic              r_carry;
    logic [c_IDXW-1:0] r_idx;
    logic              r_busy;
    logic              r_done;
    logic [WIDTH-1:0]  r_sum;
    logic              r_cout;

    logic [CHUNK-1:0]  w_a_chunk;
    logic [CHUNK-1:0]  w_b_chunk;
    logic [CHUNK:0]    w_chunk_sum;
    logic [WIDTH-1:0]  w_acc_next;

    // One CHUNK-wide adder slice; the accumulator view includes the chunk in flight
    // so the completing edge can publish the full result directly.
    always_comb begin
        w_a_chunk   = r_a[int'(r_idx) * CHUNK +: CHUNK];
        w_b_chunk   = r_b[int'(r_idx) * CHUNK +: CHUNK];
        w_chunk_sum = {1'b0, w_a_chunk} + {1'b0, w_b_chunk} + {{CHUNK{1'b0}}, r_carry};
        w_acc_next  = r_acc;
        w_acc_next[int'(r_idx) * CHUNK +: CHUNK] = w_chunk_sum[CHUNK-1:0];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= c_IDLE;
            r_a     <= '0;
            r_b     <= '0;
            r_acc   <= '0;
            r_carry <= 1'b0;
            r_idx   <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_sum   <= '0;
            r_cout  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                c_IDLE: begin
                    if (start) begin
                        r_a     <= A;
                        r_b     <= B;
                        r_carry <= Cin;
                        r_acc   <= '0;
                        r_idx   <= '0;
                        r_busy  <= 1'b1;
                        r_state <= c_RUN;
                    end
                end
                c_RUN: begin
                    r_acc   <= w_acc_next;
                    r_carry <= w_chunk_sum[CHUNK];
                    if (r_idx == c_LAST_IDX) begin
                        r_sum   <= w_acc_next;
                        r_cout  <= w_chunk_sum[CHUNK];
                        r_done  <= 1'b1;
                        r_busy  <= 1'b0;
                        r_idx   <= '0;
                        r_state <= c_IDLE;
                    end else begin
                        r_idx <= r_idx + c_IDXW'(1);
                    end
                end
                default: r_state <= c_IDLE;
            endcase
        end
    end

    assign busy = r_busy;
    assign done = r_done;
    assign Sum  = r_sum;
    assign Cout = r_cout;

endmodule
`default_nettype wire

// File: doc/serial_adder.md
Name: serial_adder

Overview:
- Multi-cycle adder: computes Sum = A + B + Cin over WIDTH/CHUNK clock cycles, CHUNK bits per cycle, carry held in a register between chunks.
- Counterpart to the combinational subtractor. Feeding B inverted with Cin=1 reconstructs a subtraction, and adding a difference back to its subtrahend checks the subtractor's result.
- Uses a start/busy/done handshake so the datapath stays narrow in area-constrained builds.

Parameters:
- WIDTH, 32, operand and result width in bits.
- CHUNK, 8, bits added per clock cycle. WIDTH must be an integer multiple of CHUNK; any other combination is illegal.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  request an operation; sampled only when busy=0.
- A  input  WIDTH  first operand; sampled on the accepting edge.
- B  input  WIDTH  second operand; sampled on the accepting edge.
- Cin  input  1  carry in; sampled on the accepting edge.
- busy  output  1  high while an operation is in progress.
- done  output  1  one-cycle pulse when Sum/Cout are updated.
- Sum  output  WIDTH  result, held until the next completion.
- Cout  output  1  carry out of bit WIDTH-1, held with Sum.

Behaviour:
- Definitions: N = WIDTH/CHUNK; chunk index idx runs 0..N-1, with chunk 0 being bits CHUNK-1:0.
- Reset (rst_n=0, asynchronous):
  - state=IDLE; busy=0, done=0, Sum=0, Cout=0.
  - Operand registers, carry register and idx cleared.
  - Reset asserted mid-operation abandons the operation; no done pulse follows.
- States: IDLE and RUN.
- IDLE:
  - start=1 at a rising edge E0: latch A, B and Cin into internal registers, set idx=0, go to RUN, busy=1.
  - start=0: remain in IDLE.
- RUN, at each edge:
  - Add chunk idx of A, chunk idx of B and the carry register.
  - Store the CHUNK-bit result into chunk idx of the internal accumulator; update the carry register.
  - idx increments by 1.
- Last chunk (at edge EN, the N-th edge after E0):
  - Sum takes the full accumulator value, including the chunk just computed.
  - Cout takes the final carry.
  - done=1, busy=0, state returns to IDLE.
- done is high exactly one cycle (EN to EN+1). Sum and Cout change only at completion edges; they stay stable during RUN.
- Latency: start sampled at E0 gives done and a valid Sum at EN. Default latency is 4 cycles.
- Back-to-back: start=1 in the cycle after EN is accepted at EN+1. done falls at EN+1 as normal. Maximum throughput is one result every N+1 cycles.
- start=1 while busy=1 is ignored, with no queuing. Changes to A, B or Cin during RUN have no effect.
- Arithmetic is unsigned modulo 2^WIDTH; Cout is the true carry. Carry propagates across chunk boundaries only through the carry register, one chunk per cycle.

Test Plan:
- Reset check: assert rst_n=0 with random inputs -> busy=0, done=0, Sum=0, Cout=0; hold start=0 after release -> outputs unchanged.
- Basic add: A=465, B=100, Cin=1, start pulse -> done exactly 4 cycles after the start edge, Sum=566, Cout=0, busy high for exactly those 4 cycles.
- Cross-chunk carry and overflow:
  - A=0x00FFFFFF, B=1, Cin=0 -> Sum=0x01000000, Cout=0.
  - Then A=0xFFFFFFFF, B=0, Cin=1 -> Sum=0, Cout=1.
- Subtraction reconstruction: A=800, B=~5254, Cin=1 -> Sum=0xFFFFEE9A, Cout=0. Then A=895, B=~100, Cin=1 -> Sum=795, Cout=1.
- Handshake edges:
  - start held high continuously with A=5, B=2, Cin=1 -> results every 5 cycles, each Sum=8; operand changes mid-RUN are ignored.
  - A second start while busy is dropped.
- Reset mid-operation: assert rst_n low 2 cycles after start -> immediate clear of all outputs, no done pulse. A new operation after release completes correctly (A=245, B=52, Cin=0 -> Sum=297).
